load_requester: RTL and testbench

- Initiator side of the memory load port: accepts word-load requests from the execute stage and drives loadEnable/loadAddr into mem.
- Records each issued request's tag and lane in an in-order tracking FIFO, then matches returning loadReady/loadData beats to it.
- Extracts the addressed 16-bit word from the 64-bit block and returns it with its tag.
- Sits between the execute/LSU logic and mem's load port; mem responses are strictly in order, fixed latency, no backpressure.

---
 rtl/load_requester.sv | 165 ++++++++++++++++
 tb/tb_load_requester.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_requester.sv
// Initiator for mem's load port: issues word loads, tracks them in an in-order
// FIFO and returns the addressed 16-bit word from each returning block with its tag.
module load_requester #(
   parameter int LATENCY = 100,
   parameter int DEPTH   = 128,
   parameter int TAGW    = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [15:0]     req_addr,
   input  logic [TAGW-1:0] req_tag,
   output logic            loadEnable,
   output logic [15:0]     loadAddr,
   input  logic            loadReady,
   input  logic [63:0]     loadData,
   output logic            resp_valid,
   output logic [TAGW-1:0] resp_tag,
   output logic [15:0]     resp_data,
   output logic            busy,
   output logic            err_illegal,
   output logic            err_spurious
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(LATENCY + 1);
   localparam int EW = TAGW + 2;

   localparam logic [0:0] S_DRAIN = 1'b0;
   localparam logic [0:0] S_RUN   = 1'b1;

   localparam logic [AW:0]   FULL_CNT   = (AW + 1)'(DEPTH);
   localparam logic [CW-1:0] DRAIN_INIT = CW'(LATENCY);

   logic [0:0]      state_q, state_d;
   logic [CW-1:0]   drain_cnt_q, drain_cnt_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     count_q, count_d;
   logic            load_en_q, load_en_d;
   logic [15:0]     load_addr_q, load_addr_d;
   logic            resp_valid_q, resp_valid_d;
   logic [TAGW-1:0] resp_tag_q, resp_tag_d;
   logic [15:0]     resp_data_q, resp_data_d;
   logic            err_ill_q, err_ill_d;
   logic            err_spur_q, err_spur_d;

   // Each entry holds {tag, lane}; the address itself is not needed on return.
   logic [EW-1:0]   fifo_q [DEPTH];
   logic [EW-1:0]   head;
   logic [15:0]     lane_word;

   logic run, full, accept, illegal, push, pop, spurious;

   assign run      = (state_q == S_RUN);
   assign full     = (count_q == FULL_CNT);
   assign req_ready = run && !full;
   assign accept   = req_valid && req_ready;
   assign illegal  = (req_addr == 16'hFFFF);
   assign push     = accept && !illegal;
   assign pop      = loadReady && run && (count_q != '0);
   assign spurious = loadReady && run && (count_q == '0);
   assign head     = fifo_q[rd_ptr_q];

   always_comb begin
      lane_word = loadData[15:0];
      case (head[1:0])
         2'd0:    lane_word = loadData[63:48];
         2'd1:    lane_word = loadData[47:32];
         2'd2:    lane_word = loadData[31:16];
         default: lane_word = loadData[15:0];
      endcase
   end

   always_comb begin
      state_d      = state_q;
      drain_cnt_d  = drain_cnt_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      load_en_d    = 1'b0;
      load_addr_d  = load_addr_q;
      resp_valid_d = 1'b0;
      resp_tag_d   = resp_tag_q;
      resp_data_d  = resp_data_q;
      err_ill_d    = err_ill_q;
      err_spur_d   = err_spur_q;

      // RUN is entered on the same edge the counter reaches zero.
      if (state_q == S_DRAIN) begin
         if (drain_cnt_q != '0) drain_cnt_d = drain_cnt_q - CW'(1);
         if (drain_cnt_q <= CW'(1)) state_d = S_RUN;
      end

      if (accept) begin
         if (illegal) begin
            err_ill_d = 1'b1;
         end else begin
            load_en_d   = 1'b1;
            load_addr_d = req_addr;
            wr_ptr_d    = wr_ptr_q + AW'(1);
         end
      end

      if (pop) begin
         rd_ptr_d     = rd_ptr_q + AW'(1);
         resp_valid_d = 1'b1;
         resp_tag_d   = head[EW-1:2];
         resp_data_d  = lane_word;
      end

      if (spurious) err_spur_d = 1'b1;

      case ({push, pop})
         2'b10:   count_d = count_q + (AW + 1)'(1);
         2'b01:   count_d = count_q - (AW + 1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_DRAIN;
         drain_cnt_q  <= DRAIN_INIT;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         load_en_q    <= 1'b0;
         load_addr_q  <= '0;
         resp_valid_q <= 1'b0;
         resp_tag_q   <= '0;
         resp_data_q  <= '0;
         err_ill_q    <= 1'b0;
         err_spur_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         drain_cnt_q  <= drain_cnt_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         load_en_q    <= load_en_d;
         load_addr_q  <= load_addr_d;
         resp_valid_q <= resp_valid_d;
         resp_tag_q   <= resp_tag_d;
         resp_data_q  <= resp_data_d;
         err_ill_q    <= err_ill_d;
         err_spur_q   <= err_spur_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_q[wr_ptr_q] <= {req_tag, req_addr[1:0]};
   end

   assign loadEnable   = load_en_q;
   assign loadAddr     = load_addr_q;
   assign resp_valid   = resp_valid_q;
   assign resp_tag     = resp_tag_q;
   assign resp_data    = resp_data_q;
   assign err_illegal  = err_ill_q;
   assign err_spurious = err_spur_q;
   assign busy         = !run || (count_q != '0) || resp_valid_q;

endmodule

// File: tb/tb_load_requester.sv
// Directed bench for load_requester with a fixed-latency, in-order mem model
// that can withhold beats or inject an unsolicited one.
module tb_load_requester;

   localparam int LAT   = 100;
   localparam int DEPTH = 128;
   localparam int TAGW  = 5;

   logic            clk = 1'b0;
   logic            rst;
   logic            req_valid;
   logic            req_ready;
   logic [15:0]     req_addr;
   logic [TAGW-1:0] req_tag;
   logic            loadEnable;
   logic [15:0]     loadAddr;
   logic            loadReady = 1'b0;
   logic [63:0]     loadData  = 64'h0;
   logic            resp_valid;
   logic [TAGW-1:0] resp_tag;
   logic [15:0]     resp_data;
   logic            busy;
   logic            err_illegal;
   logic            err_spurious;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   bit mem_stall = 1'b0;
   int rel_req = 0, rel_done = 0;
   int inj_req = 0, inj_done = 0;
   int          due_q[$];
   logic [63:0] dat_q[$];

   logic [TAGW-1:0] got_tag_q[$];
   logic [15:0]     got_data_q[$];
   int              got_cyc_q[$];
   logic [15:0]     exp_q[$];

   load_requester #(.LATENCY(LAT), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_tag(req_tag),
      .loadEnable(loadEnable), .loadAddr(loadAddr), .loadReady(loadReady), .loadData(loadData),
      .resp_valid(resp_valid), .resp_tag(resp_tag), .resp_data(resp_data),
      .busy(busy), .err_illegal(err_illegal), .err_spurious(err_spurious)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   function automatic logic [63:0] blk(input logic [13:0] b);
      case (b)
         14'd0:   blk = 64'hA000_A001_A002_A003;
         14'd1:   blk = 64'hB000_B001_B002_B003;
         14'd2:   blk = 64'h1111_2222_3333_4444;
         default: blk = {4{2'b00, b}};
      endcase
   endfunction

   // mem: request seen at edge N returns its beat so the DUT samples it at edge N+LAT+1
   always begin
      @(posedge clk);
      #1;
      if (loadEnable) begin
         due_q.push_back(cyc + 1 + LAT);
         dat_q.push_back(blk(loadAddr[15:2]));
      end
      loadReady = 1'b0;
      loadData  = 64'h0;
      if (inj_done < inj_req) begin
         inj_done++;
         loadReady = 1'b1;
         loadData  = 64'hDEAD_BEEF_DEAD_BEEF;
      end else if (due_q.size() > 0 && due_q[0] <= cyc && (!mem_stall || rel_done < rel_req)) begin
         loadReady = 1'b1;
         loadData  = dat_q.pop_front();
         void'(due_q.pop_front());
         if (mem_stall) rel_done++;
      end
   end

   always @(negedge clk) begin
      if (resp_valid) begin
         got_tag_q.push_back(resp_tag);
         got_data_q.push_back(resp_data);
         got_cyc_q.push_back(cyc);
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_resps(input int n, input int base, input int budget, input string tag);
      int k = 0;
      while (got_tag_q.size() < base + n && k < budget) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_timeout"}, 64'(got_tag_q.size() >= base + n), 64'd1);
   endtask

   task automatic issue(input logic [15:0] addr, input logic [TAGW-1:0] tag);
      req_valid = 1'b1;
      req_addr  = addr;
      req_tag   = tag;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   logic [15:0] exp_b2b [8] = '{16'hA000, 16'hA001, 16'hA002, 16'hA003,
                                16'hB000, 16'hB001, 16'hB002, 16'hB003};

   initial begin
      int k, base, acc, n_acc;
      logic busy99;
      rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_tag = '0;
      busy99 = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_req_ready", req_ready, 0);
      check("rst_load_en", loadEnable, 0);
      check("rst_load_addr", loadAddr, 0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_resp_tag", resp_tag, 0);
      check("rst_resp_data", resp_data, 0);
      check("rst_busy", busy, 1);
      check("rst_err_ill", err_illegal, 0);
      check("rst_err_spur", err_spurious, 0);

      // drain window length
      rst = 1'b0;
      k = 0;
      while (!req_ready && k < 300) begin
         @(negedge clk);
         k++;
         if (k == 99) busy99 = busy;
      end
      check("drain_len", k, 100);
      check("drain_busy_before", busy99, 1);
      check("drain_busy_after", busy, 0);

      // single load
      req_valid = 1'b1; req_addr = 16'h0009; req_tag = 5'd3;
      @(negedge clk);
      acc = cyc;
      req_valid = 1'b0;
      check("single_le", loadEnable, 1);
      check("single_la", loadAddr, 16'h0009);
      base = got_tag_q.size();
      @(negedge clk);
      check("single_le_pulse", loadEnable, 0);
      wait_resps(1, base, 300, "single");
      if (got_tag_q.size() > base) begin
         check("single_lat", got_cyc_q[base] - acc, LAT + 2);
         check("single_tag", got_tag_q[base], 3);
         check("single_data", got_data_q[base], 16'h2222);
      end

      // back-to-back
      base = got_tag_q.size();
      for (int i = 0; i < 8; i++) begin
         req_valid = 1'b1; req_addr = 16'(i); req_tag = TAGW'(i);
         exp_q.push_back(exp_b2b[i]);
         @(negedge clk);
      end
      req_valid = 1'b0;
      wait_resps(8, base, 300, "b2b");
      repeat (5) @(negedge clk);
      check("b2b_cnt", got_tag_q.size() - base, 8);
      for (int i = 0; i < 8; i++) begin
         if (got_tag_q.size() > base + i) begin
            check("b2b_tag", got_tag_q[base + i], i);
            check("b2b_data", got_data_q[base + i], exp_q.pop_front());
            check("b2b_gap", got_cyc_q[base + i] - got_cyc_q[base], i);
         end
      end
      check("b2b_idle_busy", busy, 0);

      // illegal address, then a legal one
      req_valid = 1'b1; req_addr = 16'hFFFF; req_tag = 5'd7;
      check("ill_ready", req_ready, 1);
      @(negedge clk);
      req_valid = 1'b0;
      check("ill_no_le", loadEnable, 0);
      check("ill_err", err_illegal, 1);
      base = got_tag_q.size();
      issue(16'h000A, 5'd9);
      wait_resps(1, base, 300, "ill_follow");
      repeat (5) @(negedge clk);
      check("ill_resp_cnt", got_tag_q.size() - base, 1);
      if (got_tag_q.size() > base) begin
         check("ill_follow_tag", got_tag_q[base], 9);
         check("ill_follow_data", got_data_q[base], 16'h3333);
      end

      // fill the FIFO with mem withholding beats
      mem_stall = 1'b1;
      n_acc = 0;
      base = got_tag_q.size();
      for (int i = 0; i < DEPTH; i++) begin
         req_valid = 1'b1; req_addr = 16'h0100 + 16'(i); req_tag = TAGW'(i);
         if (req_ready) n_acc++;
         @(negedge clk);
      end
      check("full_acc", n_acc, DEPTH);
      check("full_ready", req_ready, 0);
      req_addr = 16'h0300;
      @(negedge clk);
      req_valid = 1'b0;
      check("full_blocked_le", loadEnable, 0);
      rel_req++;
      @(negedge clk);
      check("full_still_blocked", req_ready, 0);
      @(negedge clk);
      check("full_reopen", req_ready, 1);
      mem_stall = 1'b0;
      wait_resps(DEPTH, base, 600, "full");
      repeat (5) @(negedge clk);
      check("full_resp_cnt", got_tag_q.size() - base, DEPTH);
      if (got_tag_q.size() >= base + DEPTH) begin
         check("full_first_tag", got_tag_q[base], 0);
         check("full_first_data", got_data_q[base], 16'h0040);
         check("full_last_tag", got_tag_q[base + DEPTH - 1], 31);
         check("full_last_data", got_data_q[base + DEPTH - 1], 16'h005F);
      end
      check("full_idle_busy", busy, 0);

      // reset with loads in flight
      base = got_tag_q.size();
      for (int i = 0; i < 10; i++) begin
         req_valid = 1'b1; req_addr = 16'h0020 + 16'(i); req_tag = TAGW'(i);
         @(negedge clk);
      end
      req_valid = 1'b0;
      repeat (40) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("mid_rst_err_ill", err_illegal, 0);
      check("mid_rst_busy", busy, 1);
      rst = 1'b0;
      repeat (150) @(negedge clk);
      check("mid_no_resp", got_tag_q.size() - base, 0);
      check("mid_err_spur", err_spurious, 0);
      check("mid_ready", req_ready, 1);
      check("mid_busy", busy, 0);
      base = got_tag_q.size();
      issue(16'h0009, 5'd3);
      wait_resps(1, base, 300, "post_rst");
      if (got_tag_q.size() > base) begin
         check("post_rst_tag", got_tag_q[base], 3);
         check("post_rst_data", got_data_q[base], 16'h2222);
      end

      // unsolicited beat while idle
      repeat (5) @(negedge clk);
      base = got_tag_q.size();
      inj_req++;
      repeat (3) @(negedge clk);
      check("spur_err", err_spurious, 1);
      check("spur_no_resp", got_tag_q.size() - base, 0);
      repeat (5) @(negedge clk);
      check("spur_sticky", err_spurious, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
